// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths and FSM state encodings for the shift stages
package shift_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SHW   = 5;

    localparam logic [1:0] IDLE_ENC  = 2'b00;
    localparam logic [1:0] SHIFT_ENC = 2'b01;
    localparam logic [1:0] DONE_ENC  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE_ENC,
        ST_SHIFT = SHIFT_ENC,
        ST_DONE  = DONE_ENC
    } state_e;

endpackage

// File: rtl/shift_right_1.sv
// rtl/shift_right_1.sv - combinational 1-bit right-shift mux stage
module shift_right_1 #(
    parameter int WIDTH = shift_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] input_a,
    input  logic             fill,
    input  logic             S,
    output logic [WIDTH-1:0] shift_result
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            logic hi;
            if (i == WIDTH - 1) begin : g_msb
                assign hi = fill;
            end else begin : g_low
                assign hi = input_a[i+1];
            end
            // AND-OR mux per bit, matching the left-shift stage
            assign shift_result[i] = (S & hi) | (~S & input_a[i]);
        end
    endgenerate

endmodule

// File: rtl/shift_right_seq.sv
// rtl/shift_right_seq.sv - iterative right shifter, one bit per clock, start/done handshake
module shift_right_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = DEFAULT_SHW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shift_result
);

    localparam logic [SHW-1:0] COUNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] stage_out;
    logic             stage_en;

    assign stage_en = (state_q == ST_SHIFT);

    shift_right_1 #(.WIDTH(WIDTH)) u_stage (
        .input_a      (data_q),
        .fill         (fill_q),
        .S            (stage_en),
        .shift_result (stage_out)
    );

    always_comb begin
        state_d = ST_IDLE;
        data_d  = stage_out;
        count_d = count_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    data_d  = input_a;
                    count_d = shamt;
                    fill_d  = arith & input_a[WIDTH-1];
                    state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                count_d = count_q - COUNT_ONE;
                state_d = (count_q == COUNT_ONE) ? ST_DONE : ST_SHIFT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            count_q <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            fill_q  <= fill_d;
        end
    end

    assign busy         = (state_q == ST_SHIFT);
    assign done         = (state_q == ST_DONE);
    assign shift_result = data_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// tb/tb_shift_right_seq.sv - scoreboard bench for shift_right_seq
module tb_shift_right_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] input_a = 32'h0;
    logic [4:0]  shamt = 5'd0;
    logic        arith = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] shift_result;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    shift_right_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .input_a      (input_a),
        .shamt        (shamt),
        .arith        (arith),
        .busy         (busy),
        .done         (done),
        .shift_result (shift_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, got, req);
        end
    endtask

    task automatic run_op(input string nm, input logic [31:0] a, input logic [4:0] sh,
                          input logic ar, input logic [31:0] req, input bit at_done,
                          input bit poke);
        int  lat;
        int  bcnt;
        bit  seen;
        lat = 0;
        bcnt = 0;
        seen = 0;
        if (!at_done) @(negedge clk);
        input_a = a;
        shamt   = sh;
        arith   = ar;
        start   = 1'b1;
        exp_q.push_back(req);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        start   = 1'b0;
        input_a = 32'h0;
        shamt   = 5'd0;
        arith   = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (poke && lat == 2) begin
                start   = 1'b1;
                input_a = 32'hFFFF_FFFF;
                shamt   = 5'd3;
                arith   = 1'b1;
            end
            if (poke && lat == 3) begin
                start   = 1'b0;
                input_a = 32'h0;
                shamt   = 5'd0;
                arith   = 1'b0;
            end
            if (done) seen = 1;
        end
        check({nm, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({nm, "_latency"}, lat, sh + 32'd1);
        check({nm, "_busy_cycles"}, bcnt, {27'b0, sh});
    endtask

    initial begin
        int stray;

        fork
            forever begin
                @(negedge clk);
                if (!reset && done) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_done got=%h required=no_done", shift_result);
                    end else begin
                        logic [31:0] e;
                        string       n;
                        e = exp_q.pop_front();
                        n = name_q.pop_front();
                        if (shift_result !== e) begin
                            failures++;
                            $display("FAIL %s_result got=%h required=%h", n, shift_result, e);
                        end
                    end
                end
            end
        join_none

        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", shift_result, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_op("srl4", 32'hF000_0001, 5'd4, 1'b0, 32'h0F00_0000, 0, 0);
        run_op("sra4", 32'hF000_0001, 5'd4, 1'b1, 32'hFF00_0000, 0, 0);
        run_op("sra31", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 0, 0);
        run_op("srl31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 0, 0);
        run_op("zero", 32'hDEAD_BEEF, 5'd0, 1'b0, 32'hDEAD_BEEF, 0, 0);

        // result is nonzero here, so async reset must visibly clear it
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_busy", {31'b0, busy}, 32'd0);
        check("async_reset_done", {31'b0, done}, 32'd0);
        check("async_reset_result", shift_result, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op("ignored_start", 32'h1234_5678, 5'd8, 1'b0, 32'h0012_3456, 0, 1);
        run_op("back_to_back", 32'h0000_0010, 5'd4, 1'b0, 32'h0000_0001, 1, 0);

        // abort: four negedges after accept the count has reached 3
        @(negedge clk);
        input_a = 32'h0000_FF00;
        shamt   = 5'd6;
        arith   = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_before_reset", {31'b0, busy}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("mid_reset_busy", {31'b0, busy}, 32'd0);
        check("mid_reset_done", {31'b0, done}, 32'd0);
        check("mid_reset_result", shift_result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        check("mid_reset_no_done", stray, 32'd0);

        run_op("after_abort", 32'h0000_0002, 5'd1, 1'b0, 32'h0000_0001, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
